// File: rtl/prefetch_pkg.sv
// Shared types and default sizes for the instruction prefetch unit.
// Optional statistics counters are enabled with the PREFETCH_STATS_EN macro.
package prefetch_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_AW    = 8;
    localparam int DEF_IW    = 8;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } prefetch_state_t;

    typedef struct packed {
        logic [DEF_IW-1:0] code;
        logic [DEF_AW-1:0] pc;
    } prefetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Instruction queue for the prefetch unit: DEPTH entries, synchronous clear,
// head entry always visible on rdata.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int  DEPTH   = DEF_DEPTH,
    parameter type entry_t = prefetch_entry_t,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  entry_t        wdata,
    output entry_t        rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: credit-limited fetch requests, in-order response queue,
// flush/drain handling. Define PREFETCH_STATS_EN to add fetch/stall counters.
module instr_prefetch
    import prefetch_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int IW    = DEF_IW
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [AW-1:0]   imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [IW-1:0]   imem_rdata,
    input  logic            flush,
    input  logic [AW-1:0]   flush_pc,
    input  logic            stall,
    output logic            instr_valid,
    output logic [IW-1:0]   instr_code,
    output logic [AW-1:0]   instr_pc,
`ifdef PREFETCH_STATS_EN
    output logic [15:0]     fetch_count,
    output logic [15:0]     stall_count,
`endif
    output prefetch_state_t state_dbg
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [IW-1:0] code;
        logic [AW-1:0] pc;
    } entry_t;

    prefetch_state_t state;
    prefetch_state_t state_nxt;
    logic [AW-1:0]   fetch_pc;
    logic [AW-1:0]   resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   q_count;
    logic            q_full;
    logic            q_empty;
    logic            credit_ok;
    logic            accept;
    logic            rsp;
    logic            push;
    logic            pop;
    entry_t          q_wdata;
    entry_t          q_rdata;

    // Handshake: a request transfers on a cycle with imem_req && imem_gnt; the
    // address is held until then. Responses return in order, one per cycle.
    assign credit_ok = ({1'b0, q_count} + {1'b0, outstanding}) < (CW + 1)'(DEPTH);
    assign accept    = imem_req && imem_gnt;
    assign rsp       = imem_rvalid && (outstanding != '0);
    assign outstanding_nxt = outstanding + CW'(accept) - CW'(rsp);

    assign push    = rsp && (state == RUN) && !flush && !q_full;
    assign pop     = !q_empty && !stall && !flush;
    assign q_wdata = '{code: imem_rdata, pc: resp_pc};

    assign imem_addr   = fetch_pc;
    assign instr_valid = !q_empty;
    assign instr_code  = q_rdata.code;
    assign instr_pc    = q_rdata.pc;
    assign state_dbg   = state;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                imem_req = credit_ok && !flush;
                if (flush && (outstanding_nxt != '0)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!flush && (outstanding_nxt == '0)) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    // resp_pc tracks the address of the next response that will be kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            fetch_pc    <= '0;
            resp_pc     <= '0;
            outstanding <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            if (flush) begin
                fetch_pc <= flush_pc;
                resp_pc  <= flush_pc;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 1'b1;
                end
                if (push) begin
                    resp_pc <= resp_pc + 1'b1;
                end
            end
        end
    end

    prefetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (pop && (fetch_count != 16'hFFFF)) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (instr_valid && stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with a latency-programmable memory model
// and a scoreboard of expected requests and delivered instructions.
`timescale 1ns/1ps
module tb_instr_prefetch;
    import prefetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int IW    = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            imem_req;
    logic [AW-1:0]   imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [IW-1:0]   imem_rdata;
    logic            flush;
    logic [AW-1:0]   flush_pc;
    logic            stall;
    logic            instr_valid;
    logic [IW-1:0]   instr_code;
    logic [AW-1:0]   instr_pc;
    prefetch_state_t state_dbg;
`ifdef PREFETCH_STATS_EN
    logic [15:0]     fetch_count;
    logic [15:0]     stall_count;
`endif

    instr_prefetch #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr_code  (instr_code),
        .instr_pc    (instr_pc),
`ifdef PREFETCH_STATS_EN
        .fetch_count (fetch_count),
        .stall_count (stall_count),
`endif
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [AW+IW-1:0] exp_q[$];       // {code, pc}
    logic [AW-1:0]    exp_addr_q[$];
    int               pop_log[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;
    pend_t pend_q[$];
    pend_t p;

    int cyc         = 0;
    int accepts     = 0;
    int grant_limit = 0;
    int lat         = 1;
    bit mon_en      = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_instr(input logic [AW-1:0] a);
        logic [IW-1:0] c;
        c = a + 8'h10;
        exp_addr_q.push_back(a);
        exp_q.push_back({c, a});
    endtask

    task automatic grant(input int n);
        grant_limit = accepts + n;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp_addr_q.size() == 0 && pend_q.size() == 0 && !instr_valid)
                done = 1'b1;
        end
        check({name, "_complete"}, 32'(done), 32'd1);
    endtask

    // ---------------- memory model ----------------
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            #2;
            if (!rst) pend_q.delete();
            imem_gnt = rst && (accepts < grant_limit);
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                p           = pend_q.pop_front();
                imem_rvalid = 1'b1;
                imem_rdata  = p.addr + 8'h10;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
            #1;
            if (rst && imem_req && imem_gnt) begin
                accepts++;
                if (mon_en) begin
                    if (exp_addr_q.size() == 0)
                        check("req_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
                    else
                        check("imem_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
                end
                pend_q.push_back('{addr: imem_addr, due: cyc + lat});
            end
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        logic [AW+IW-1:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (rst && mon_en && instr_valid && !stall && !flush) begin
                pop_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("instr_unexpected", {16'd0, instr_code, instr_pc}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_code", 32'(instr_code), 32'(e[AW+IW-1:AW]));
                    check("instr_pc", 32'(instr_pc), 32'(e[AW-1:0]));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int base;
        bit seen;
        stall    = 1'b0;
        flush    = 1'b0;
        flush_pc = '0;
        rst      = 1'b0;

        // reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_code", 32'(instr_code), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(BOOT));
`ifdef PREFETCH_STATS_EN
        check("rst_fetch_count", 32'(fetch_count), 32'd0);
        check("rst_stall_count", 32'(stall_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("boot_to_run", 32'(state_dbg), 32'(RUN));

        // streaming, one instruction per cycle
        pop_log.delete();
        for (int i = 0; i < 8; i++) exp_instr(AW'(i));
        grant(8);
        wait_idle("t1");
        check("t1_pop_count", 32'(pop_log.size()), 32'd8);
        if (pop_log.size() == 8)
            check("t1_back_to_back", 32'(pop_log[7] - pop_log[0]), 32'd7);

        // credit limit under stall
        stall = 1'b1;
        for (int i = 8; i < 16; i++) exp_instr(AW'(i));
        base = accepts;
        grant(8);
        repeat (10) @(negedge clk);
        #1;
        check("t2_issued", 32'(accepts - base), 32'd4);
        check("t2_req_low", 32'(imem_req), 32'd0);
        check("t2_valid", 32'(instr_valid), 32'd1);
        @(negedge clk);
        stall = 1'b0;
        wait_idle("t2");

        // flush with three outstanding requests
        lat = 3;
        base = accepts;
        exp_addr_q.push_back(8'h10);
        exp_addr_q.push_back(8'h11);
        exp_addr_q.push_back(8'h12);
        grant(3);
        for (int i = 0; i < 20 && (accepts - base) < 3; i++) @(negedge clk);
        @(negedge clk);
        check("t3_outstanding", 32'(accepts - base), 32'd3);
        flush    = 1'b1;
        flush_pc = 8'h40;
        for (int i = 0; i < 3; i++) exp_instr(AW'(8'h40 + i));
        grant(3);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("t3_drain", 32'(state_dbg), 32'(DRAIN));
        check("t3_drain_req", 32'(imem_req), 32'd0);
        wait_idle("t3");

        // address wrap
        lat = 1;
        @(negedge clk);
        flush    = 1'b1;
        flush_pc = 8'hFE;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("t4_stay_run", 32'(state_dbg), 32'(RUN));
        exp_instr(8'hFE);
        exp_instr(8'hFF);
        exp_instr(8'h00);
        exp_instr(8'h01);
        grant(4);
        wait_idle("t4");

        // grant withheld: request and address held
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("t5_hold_addr", 32'(imem_addr), 32'h02);
            check("t5_hold_req", 32'(imem_req), 32'd1);
        end

        // asynchronous reset mid-stream
        mon_en = 1'b0;
        lat    = 2;
        grant(1000);
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t5_rst_req", 32'(imem_req), 32'd0);
        check("t5_rst_valid", 32'(instr_valid), 32'd0);
        check("t5_rst_code", 32'(instr_code), 32'd0);
        check("t5_rst_pc", 32'(instr_pc), 32'd0);
        check("t5_rst_addr", 32'(imem_addr), 32'd0);
        check("t5_rst_state", 32'(state_dbg), 32'(BOOT));
        grant(0);
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
        lat    = 1;
        for (int i = 0; i < 3; i++) exp_instr(AW'(i));
        grant(3);
        wait_idle("t5");

        // stall accounting: 7 more pops, 3 stalled cycles with valid
        stall = 1'b1;
        for (int i = 3; i < 10; i++) exp_instr(AW'(i));
        grant(7);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = instr_valid;
        end
        check("t6_valid_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        stall = 1'b0;
        wait_idle("t6");
`ifdef PREFETCH_STATS_EN
        #1;
        check("fetch_count", 32'(fetch_count), 32'd10);
        check("stall_count", 32'(stall_count), 32'd3);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, instruction queue depth (power of two, 2..16).
REQ-002 Parameter AW, default 8, PC/address width.
REQ-003 Parameter IW, default 8, instruction width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 imem_req  output  1  fetch request valid.
REQ-007 imem_addr  output  AW  fetch address (current fetch PC).
REQ-008 imem_gnt  input  1  memory accepts request this cycle.
REQ-009 imem_rvalid  input  1  read data valid; in-order, at most one per cycle, any latency >=1.
REQ-010 imem_rdata  input  IW  instruction word.
REQ-011 flush  input  1  redirect pulse from downstream.
REQ-012 flush_pc  input  AW  redirect target, sampled when flush=1.
REQ-013 stall  input  1  downstream cannot accept instruction.
REQ-014 instr_valid  output  1  instr_code/instr_pc valid.
REQ-015 instr_code  output  IW  instruction to decode stage.
REQ-016 instr_pc  output  AW  address of instr_code.

Function
REQ-017 FSM states BOOT, RUN, DRAIN shall exist; BOOT entered on reset, RUN one cycle after reset release.
REQ-018 In BOOT imem_req shall be 0.
REQ-019 In RUN imem_req shall be 1 when queue occupancy + outstanding requests < DEPTH and flush=0.
REQ-020 Request shall be accepted when imem_req && imem_gnt; fetch PC then increments by 1, wrapping 2^AW-1 -> 0.
REQ-021 imem_addr shall hold stable while imem_req=1 and imem_gnt=0.
REQ-022 Each imem_rvalid in RUN shall push {imem_rdata, PC of matching request} into the queue; credit rule guarantees no overflow.
REQ-023 instr_valid shall equal queue non-empty; head entry drives instr_code/instr_pc; pop when instr_valid && !stall.
REQ-024 Push and pop in the same cycle shall leave occupancy unchanged; push into empty queue visible on instr_valid next cycle (1-cycle rvalid-to-output latency).
REQ-025 flush shall clear the queue, set fetch PC to flush_pc next cycle, force imem_req=0 that cycle; any pop that cycle is void.
REQ-026 On flush with outstanding requests >0 (including one granted in the flush cycle), FSM shall enter DRAIN; otherwise stay in RUN.
REQ-027 In DRAIN imem_req=0 and every imem_rvalid shall be discarded; return to RUN the cycle after outstanding reaches 0.
REQ-028 rvalid coincident with flush shall be discarded and counted against outstanding.
REQ-029 flush in DRAIN shall update fetch PC to new flush_pc and remain in DRAIN.

Reset
REQ-030 On rst=0: state=BOOT, fetch PC=0, queue empty, outstanding=0, imem_req=0, instr_valid=0, instr_code=0, instr_pc=0.
REQ-031 Reset mid-transaction shall abandon outstanding requests; memory side is reset by the same rst.

Configuration
REQ-032 Macro PREFETCH_STATS_EN defined: adds output fetch_count (16 bits, reset 0) counting pops, saturating at 16'hFFFF, and output stall_count (16 bits, reset 0) counting cycles with instr_valid && stall, saturating.
REQ-033 Macro undefined: those ports and counters shall not exist; all other behaviour identical.

Structure
REQ-034 Package prefetch_pkg shall hold the FSM state enum, default DEPTH/AW/IW constants, and the queue entry struct {code, pc}.
REQ-035 Queue shall be a sub-module prefetch_fifo (DEPTH entries, push/pop/clear, full/empty/count); credit/FSM logic stays in instr_prefetch.

Verification
REQ-036 Reset then gnt=1, 1-cycle rvalid, stall=0, memory word=addr+8'h10 -> imem_addr 0,1,2,...; instr_code 10,11,12 with instr_pc 0,1,2, one per cycle.
REQ-037 stall=1 held, memory always grants -> exactly DEPTH (4) requests issued, imem_req=0 afterwards; release stall -> 4 instructions in order, fetching resumes.
REQ-038 3 requests outstanding with 3-cycle latency, flush with flush_pc=8'h40 -> FSM DRAIN, 3 responses discarded, next imem_addr=8'h40, first delivered instr_pc=8'h40.
REQ-039 Fetch PC at 8'hFE -> addresses FE, FF, 00, 01; instr_pc wraps identically.
REQ-040 gnt held 0 for 5 cycles -> imem_addr constant, imem_req stays 1; rst pulsed mid-stream -> all outputs to reset values asynchronously, fetch restarts at 0.
REQ-041 With PREFETCH_STATS_EN: 10 pops, 3 stall cycles -> fetch_count=10, stall_count=3.
